// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - instruction sequencer driving a combinational 4-bit ALU
module alu_seq #(
  parameter int DW  = 4,
  parameter int RAW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [2:0]     instr_op,
  input  logic [RAW-1:0] instr_rd,
  input  logic [RAW-1:0] instr_ra,
  input  logic [RAW-1:0] instr_rb,
  input  logic           instr_usec,
  input  logic           ld_en,
  input  logic [RAW-1:0] ld_addr,
  input  logic [DW-1:0]  ld_data,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic           alu_c,
  output logic [2:0]     alu_s,
  input  logic [DW-1:0]  alu_o,
  input  logic           alu_cout,
  output logic           done,
  output logic [DW-1:0]  result,
  output logic           cflag,
  input  logic [RAW-1:0] rd_addr,
  output logic [DW-1:0]  rd_data
);

  localparam int NREG = 2 ** RAW;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_ROT = 3'd5;

  logic [1:0]     state;
  logic [RAW-1:0] rd_q;
  logic [2:0]     op_q;
  logic [DW-1:0]  regf [NREG];
  logic           accept;

  assign instr_ready = (state == IDLE);
  assign accept      = instr_valid & instr_ready;
  assign rd_data     = regf[rd_addr];

  // Sequencing: accept in IDLE, let the ALU settle in EXEC, hold done through WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rd_q  <= '0;
      op_q  <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rd_q  <= instr_rd;
            op_q  <= instr_op;
            state <= EXEC;
          end
        end
        EXEC: begin
          done  <= 1'b1;
          state <= WB;
        end
        WB: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // ALU drive registers: loaded only on accept so they hold between instructions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_c <= 1'b0;
      alu_s <= '0;
    end else if (accept) begin
      alu_a <= regf[instr_ra];
      alu_b <= regf[instr_rb];
      alu_s <= instr_op;
      alu_c <= instr_usec ? cflag : 1'b0;
    end
  end

  // Result and carry capture at the end of EXEC; only ADD and ROT produce a carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      cflag  <= 1'b0;
    end else if (state == EXEC) begin
      result <= alu_o;
      if (op_q == OP_ADD || op_q == OP_ROT) begin
        cflag <= alu_cout;
      end
    end
  end

  // Register file: the writeback is assigned after the load so it wins a same-edge collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regf[i] <= '0;
      end
    end else begin
      if (ld_en) begin
        regf[ld_addr] <= ld_data;
      end
      if (state == EXEC) begin
        regf[rd_q] <= alu_o;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with a behavioural ALU and model
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid, instr_ready, instr_usec;
  logic [2:0] instr_op;
  logic [1:0] instr_rd, instr_ra, instr_rb;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [3:0] ld_data;
  logic [3:0] alu_a, alu_b, alu_o;
  logic       alu_c, alu_cout;
  logic [2:0] alu_s;
  logic       done, cflag;
  logic [3:0] result;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq #(.DW(4), .RAW(2)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb), .instr_usec(instr_usec),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_s(alu_s),
    .alu_o(alu_o), .alu_cout(alu_cout),
    .done(done), .result(result), .cflag(cflag),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // Behavioural 4-bit ALU responder; returns {cout, o}. ROT is rotate-left with cout = old msb.
  function automatic logic [4:0] alu_f(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b,
                                       input logic c);
    case (s)
      3'd0: return {1'b0, ~a};
      3'd1: return {1'b0, a} + {1'b0, b} + {4'b0, c};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {a[3], a[2:0], a[3]};
      3'd6: return 5'd0;
      default: return {1'b0, 4'hf};
    endcase
  endfunction

  assign {alu_cout, alu_o} = alu_f(alu_s, alu_a, alu_b, alu_c);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an instruction is computed from the register contents seen at accept,
  // and its result lands in the register file one edge later.
  logic [3:0] m_regs [4];
  logic [3:0] m_a, m_b, m_result;
  logic       m_c, m_cflag, m_done;
  logic [2:0] m_s;
  logic [1:0] m_rd;
  int         m_age;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
      m_a = 0; m_b = 0; m_c = 0; m_s = 0; m_rd = 0;
      m_result = 0; m_cflag = 0; m_done = 0; m_age = 0;
    end else begin
      logic [4:0] r;
      logic       took;
      took = (m_age == 0) && instr_valid;
      if (took) begin
        m_a = m_regs[instr_ra];
        m_b = m_regs[instr_rb];
        m_c = instr_usec ? m_cflag : 1'b0;
        m_s = instr_op;
        m_rd = instr_rd;
      end
      if (ld_en) m_regs[ld_addr] = ld_data;
      m_done = 1'b0;
      if (m_age == 1) begin
        r = alu_f(m_s, m_a, m_b, m_c);
        m_regs[m_rd] = r[3:0];
        m_result = r[3:0];
        m_done = 1'b1;
        if (m_s == 3'd1 || m_s == 3'd5) m_cflag = r[4];
      end
      if (took) m_age = 1;
      else if (m_age == 1) m_age = 2;
      else m_age = 0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("instr_ready", instr_ready, m_age == 0);
      chk("done", done, m_done);
      chk("result", result, m_result);
      chk("cflag", cflag, m_cflag);
      chk("rd_data", rd_data, m_regs[rd_addr]);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_c", alu_c, m_c);
      chk("alu_s", alu_s, m_s);
      if (done) done_cnt++;
    end
  end

  task automatic load(input logic [1:0] a, input logic [3:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #2;
    ld_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input logic usec, input bit keep, output int acc);
    logic r;
    acc = -1;
    instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb; instr_usec = usec;
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); r = instr_ready;
      @(posedge clk); #2;
      if (r) begin
        acc = cyc;
        if (!keep) instr_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 0, 1);
    instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        @(posedge clk); #2;
        return;
      end
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic peek(input logic [1:0] a, input logic [3:0] exp, input string name);
    rd_addr = a; #1;
    chk(name, rd_data, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a1, a2, a3, d0;
    rst = 1'b1; instr_valid = 0; instr_op = 0; instr_rd = 0; instr_ra = 0; instr_rb = 0;
    instr_usec = 0; ld_en = 0; ld_addr = 0; ld_data = 0; rd_addr = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", instr_ready, 1);
    chk("reset_done", done, 0);
    @(posedge clk); #2;
    peek(2'd3, 4'd0, "reset_r3");

    // ADD with no carry-in: 9 + 8 = 17 -> 1, carry 1
    load(2'd0, 4'd9);
    load(2'd1, 4'd8);
    issue(3'd1, 2'd2, 2'd0, 2'd1, 1'b0, 0, a1);
    chk("add_alu_a", alu_a, 9);
    chk("add_alu_b", alu_b, 8);
    chk("add_alu_s", alu_s, 1);
    @(negedge clk); chk("add_done_exec", done, 0);
    @(negedge clk); chk("add_done_wb", done, 1); chk("add_result", result, 1);
    @(posedge clk); #2;
    peek(2'd2, 4'd1, "add_r2");
    chk("add_cflag", cflag, 1);

    // Carry chain: 9 + 9 + 1 = 19 -> 3, carry 1; then AND leaves carry alone
    issue(3'd1, 2'd3, 2'd0, 2'd0, 1'b1, 0, a1);
    chk("chain_alu_c", alu_c, 1);
    wait_idle();
    peek(2'd3, 4'd3, "chain_r3");
    chk("chain_cflag", cflag, 1);
    issue(3'd2, 2'd3, 2'd0, 2'd1, 1'b0, 0, a1);
    wait_idle();
    peek(2'd3, 4'd8, "and_r3");
    chk("and_cflag", cflag, 1);

    // Constants
    issue(3'd6, 2'd1, 2'd0, 2'd0, 1'b0, 0, a1);
    wait_idle();
    peek(2'd1, 4'd0, "zero_r1");
    chk("zero_cflag", cflag, 1);
    issue(3'd7, 2'd1, 2'd0, 2'd0, 1'b0, 0, a1);
    wait_idle();
    peek(2'd1, 4'd15, "ones_r1");
    chk("ones_cflag", cflag, 1);

    // Back-to-back with instr_valid held: XOR 9^15=6, NOT ~9=6, ROT 9 -> 3 carry 1
    d0 = done_cnt;
    issue(3'd4, 2'd1, 2'd0, 2'd1, 1'b0, 1, a1);
    issue(3'd0, 2'd2, 2'd0, 2'd0, 1'b0, 1, a2);
    issue(3'd5, 2'd3, 2'd0, 2'd0, 1'b0, 0, a3);
    wait_idle();
    chk("hs_gap12", a2 - a1, 3);
    chk("hs_gap23", a3 - a2, 3);
    chk("hs_dones", done_cnt - d0, 3);
    peek(2'd1, 4'd6, "hs_xor_r1");
    peek(2'd2, 4'd6, "hs_not_r2");
    peek(2'd3, 4'd3, "hs_rot_r3");
    chk("hs_rot_cflag", cflag, 1);

    // Load colliding with writeback to r2: 9 + 9 = 18 -> 2 wins over loaded 5
    issue(3'd1, 2'd2, 2'd0, 2'd0, 1'b0, 0, a1);
    ld_en = 1'b1; ld_addr = 2'd2; ld_data = 4'd5;
    @(posedge clk); #2;
    ld_en = 1'b0;
    wait_idle();
    peek(2'd2, 4'd2, "coll_wb_r2");

    // Load to ra on the accept edge: old r0=9 used, 9|6 = 15; r0 becomes 4
    ld_en = 1'b1; ld_addr = 2'd0; ld_data = 4'd4;
    issue(3'd3, 2'd3, 2'd0, 2'd1, 1'b0, 0, a1);
    ld_en = 1'b0;
    wait_idle();
    peek(2'd3, 4'd15, "coll_ra_r3");
    peek(2'd0, 4'd4, "coll_ra_r0");

    // Reset in the middle of EXEC: no done, everything cleared
    issue(3'd1, 2'd1, 2'd0, 2'd0, 1'b0, 0, a1);
    rst = 1'b1;
    #1;
    chk("rst_done_now", done, 0);
    chk("rst_cflag_now", cflag, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); chk("rst_done_hold", done, 0);
    end
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_done_after", done, 0);
    chk("rst_cflag", cflag, 0);
    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) peek(i[1:0], 4'd0, "rst_reg");
    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
